// File: rtl/prog_mem_pkg.sv
// prog_mem_pkg: shared constants and loader state type for the program-memory loader
package prog_mem_pkg;
   localparam int ADDR_W = 11;
   localparam int DATA_W = 14;
   localparam int DEPTH  = 2048;
   localparam int CNT_W  = ADDR_W + 1;
   typedef enum logic [1:0] {L_IDLE, L_LOAD, L_DONE} loader_state_t;
endpackage

// File: rtl/prog_mem_loader_if.sv
// prog_mem_loader_if: instruction-word stream handshake (data, valid from master; ready from slave)
interface prog_mem_loader_if;
   import prog_mem_pkg::*;
   logic [DATA_W-1:0] data;
   logic              valid;
   logic              ready;
   modport master (output data, valid, input ready);
   modport slave  (input data, valid, output ready);
endinterface

// File: rtl/prog_mem_loader_ram.sv
// prog_ram: DATA_W x DEPTH RAM; one write port and a registered read port (read-before-write)
// ports: clk, reset (clears read register only), we/waddr/wdata, raddr -> rdata one cycle later
module prog_ram
   import prog_mem_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [DEPTH];
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end
   always_ff @(posedge clk) begin
      rdata <= reset ? '0 : mem[raddr];
   end
endmodule

// File: rtl/prog_mem_loader.sv
// prog_mem_loader: streams instruction words into program RAM, holds the CPU until the load completes
// ports: clk, reset, start/abort/word_count control, stream (slave handshake), cpu_addr -> cpu_data,
//        cpu_hold/load_done status, checksum and wr_ptr of the current session
module prog_mem_loader
   import prog_mem_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               abort,
   input  logic [CNT_W-1:0]   word_count,
   prog_mem_loader_if.slave   stream,
   input  logic [ADDR_W-1:0]  cpu_addr,
   output logic [DATA_W-1:0]  cpu_data,
   output logic               cpu_hold,
   output logic               load_done,
   output logic [15:0]        checksum,
   output logic [CNT_W-1:0]   wr_ptr
);
   loader_state_t    state, state_n;
   logic [CNT_W-1:0] count, count_n, wr_ptr_n;
   logic [15:0]      checksum_n;
   logic             fire;
   // ready decodes straight from the state register, so nothing combinational reaches it from valid
   assign stream.ready = state == L_LOAD;
   assign fire         = stream.ready && stream.valid;
   assign cpu_hold     = state != L_DONE;
   assign load_done    = state == L_DONE;
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= L_IDLE;
         count    <= '0;
         wr_ptr   <= '0;
         checksum <= '0;
      end else begin
         state    <= state_n;
         count    <= count_n;
         wr_ptr   <= wr_ptr_n;
         checksum <= checksum_n;
      end
   end
   always_comb begin
      state_n    = state;
      count_n    = count;
      wr_ptr_n   = wr_ptr;
      checksum_n = checksum;
      if (state == L_LOAD) begin
         if (fire) begin
            wr_ptr_n   = wr_ptr + 1'b1;
            checksum_n = checksum + 16'(stream.data);
         end
         // abort outranks completion; a word taken in the abort cycle is still stored
         if (abort) state_n = L_IDLE;
         else if (fire && wr_ptr == count - 1'b1) state_n = L_DONE;
      end else if (start) begin
         if (word_count == '0) begin
            state_n    = L_DONE;
            checksum_n = '0;
         end else begin
            state_n    = L_LOAD;
            count_n    = (word_count > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : word_count;
            wr_ptr_n   = '0;
            checksum_n = '0;
         end
      end
   end
   prog_ram u_ram (
      .clk   (clk),
      .reset (reset),
      .we    (fire && !reset),
      .waddr (wr_ptr[ADDR_W-1:0]),
      .wdata (stream.data),
      .raddr (cpu_addr),
      .rdata (cpu_data)
   );
endmodule

// File: tb/tb_prog_mem_loader.sv
// tb_prog_mem_loader: scoreboard bench for prog_mem_loader with a word-level reference model
module tb_prog_mem_loader;
   logic        clk = 0;
   logic        reset = 1;
   logic        start = 0;
   logic        abort = 0;
   logic [11:0] word_count = '0;
   logic [10:0] cpu_addr = '0;
   logic [13:0] cpu_data;
   logic        cpu_hold, load_done;
   logic [15:0] checksum;
   logic [11:0] wr_ptr;
   logic        rd_req = 0;
   int          vectors = 0;
   int          miscompares = 0;
   typedef struct {int n; logic [15:0] sum;} sess_t;
   sess_t       exp_q[$];
   logic [13:0] rd_q[$];
   logic [13:0] wq[$];
   logic [13:0] model_mem [2048];
   prog_mem_loader_if bus ();
   prog_mem_loader dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .abort      (abort),
      .word_count (word_count),
      .stream     (bus),
      .cpu_addr   (cpu_addr),
      .cpu_data   (cpu_data),
      .cpu_hold   (cpu_hold),
      .load_done  (load_done),
      .checksum   (checksum),
      .wr_ptr     (wr_ptr)
   );
   always #5 clk = ~clk;
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask
   // monitor: read-data scoreboard and per-session completion scoreboard
   initial begin
      logic  rd_prev = 0;
      logic  prev_done = 0;
      int    xfers = 0;
      sess_t e;
      forever begin
         @(negedge clk);
         if (rd_prev) begin
            if (rd_q.size() == 0) chk("rd_q_underflow", 1, 0);
            else chk("cpu_data", cpu_data, rd_q.pop_front());
         end
         rd_prev = rd_req;
         if (load_done && !prev_done) begin
            if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
               e = exp_q.pop_front();
               chk("sess_wr_ptr", wr_ptr, e.n);
               chk("sess_checksum", checksum, e.sum);
               chk("sess_xfers", xfers, e.n);
            end
         end
         prev_done = load_done;
         if (start && !bus.ready) xfers = 0;
         else if (bus.valid && bus.ready) xfers++;
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic fill_wq(int n);
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back(14'($urandom));
   endtask
   task automatic do_start(int wc);
      start = 1;
      word_count = 12'(wc);
      tick();
      start = 0;
   endtask
   task automatic send_word(logic [13:0] d, int idx, bit gaps);
      bit ok = 0;
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      bus.valid = 1;
      bus.data = d;
      for (int t = 0; t < 50 && !ok; t++) begin
         ok = bus.ready;
         tick();
      end
      bus.valid = 0;
      if (ok) model_mem[idx] = d;
      else chk("send_timeout", 0, 1);
   endtask
   task automatic session(int wc, int stop_after, bit gaps, bit poke);
      int n, m;
      logic [15:0] s = 0;
      n = (wc > 2048) ? 2048 : wc;
      m = (stop_after < 0) ? n : stop_after;
      for (int i = 0; i < n; i++) s += 16'(wq[i]);
      if (stop_after < 0) exp_q.push_back('{n, s});
      do_start(wc);
      for (int i = 0; i < m; i++) begin
         if (poke && i == 1) do_start(7);
         send_word(wq[i], i, gaps);
      end
      if (stop_after >= 0) begin
         abort = 1;
         tick();
         abort = 0;
      end
   endtask
   task automatic wait_done();
      bit ok = 0;
      for (int t = 0; t < 10 && !ok; t++) begin
         ok = load_done;
         if (!ok) tick();
      end
      if (!ok) chk("done_timeout", 0, 1);
   endtask
   task automatic post_check(int n);
      bus.valid = 1;
      bus.data = 14'($urandom);
      repeat (2) tick();
      bus.valid = 0;
      chk("post_wr_ptr", wr_ptr, n);
      chk("post_in_ready", bus.ready, 0);
      chk("post_load_done", load_done, 1);
      chk("post_cpu_hold", cpu_hold, 0);
   endtask
   task automatic rd(int a);
      cpu_addr = 11'(a);
      rd_req = 1;
      rd_q.push_back(model_mem[a]);
      tick();
      rd_req = 0;
   endtask
   initial begin
      bus.valid = 0;
      bus.data = '0;
      repeat (2) tick();
      chk("rst_in_ready", bus.ready, 0);
      chk("rst_cpu_hold", cpu_hold, 1);
      chk("rst_load_done", load_done, 0);
      chk("rst_checksum", checksum, 0);
      chk("rst_wr_ptr", wr_ptr, 0);
      chk("rst_cpu_data", cpu_data, 0);
      reset = 0;
      tick();
      session(0, -1, 0, 0);
      wait_done();
      chk("zero_cpu_hold", cpu_hold, 0);
      wq = '{14'h3005, 14'h3E03, 14'h3A0F};
      session(3, -1, 0, 0);
      wait_done();
      chk("fixed_checksum", checksum, 16'hA817);
      post_check(3);
      rd(0); rd(1); rd(2);
      fill_wq(4);
      session(4, -1, 1, 1);
      wait_done();
      post_check(4);
      for (int a = 0; a < 4; a++) rd(a);
      fill_wq(5);
      session(5, 2, 1, 0);
      chk("abort_load_done", load_done, 0);
      chk("abort_cpu_hold", cpu_hold, 1);
      chk("abort_in_ready", bus.ready, 0);
      chk("abort_wr_ptr", wr_ptr, 2);
      fill_wq(1);
      session(1, -1, 0, 0);
      wait_done();
      rd(0); rd(1);
      fill_wq(2048);
      session(12'hFFF, -1, 0, 0);
      wait_done();
      post_check(2048);
      repeat (8) rd($urandom_range(0, 2047));
      fill_wq(3);
      do_start(3);
      send_word(wq[0], 0, 0);
      reset = 1;
      tick();
      chk("midrst_in_ready", bus.ready, 0);
      chk("midrst_cpu_hold", cpu_hold, 1);
      chk("midrst_load_done", load_done, 0);
      chk("midrst_checksum", checksum, 0);
      chk("midrst_wr_ptr", wr_ptr, 0);
      chk("midrst_cpu_data", cpu_data, 0);
      reset = 0;
      tick();
      rd(0);
      fill_wq(2);
      exp_q.push_back('{2, 16'(wq[0]) + 16'(wq[1])});
      do_start(2);
      chk("rdw_in_ready", bus.ready, 1);
      bus.valid = 1;
      bus.data = wq[0];
      cpu_addr = '0;
      rd_req = 1;
      rd_q.push_back(model_mem[0]);
      tick();
      rd_req = 0;
      bus.valid = 0;
      model_mem[0] = wq[0];
      send_word(wq[1], 1, 0);
      wait_done();
      rd(0); rd(1);
      repeat (3) tick();
      chk("exp_q_empty", exp_q.size(), 0);
      chk("rd_q_empty", rd_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/prog_mem_loader.md
Name: prog_mem_loader

Overview:
- Writer side of the CPU program-memory interface.
- Accepts a stream of 14-bit instruction words over a valid/ready handshake and writes them into an internal program RAM. The RAM replaces the fixed program ROM.
- Serves CPU fetches from a registered read port.
- Holds the CPU in reset while loading and releases it once the programmed word count has been written.

Parameters:
- ADDR_W, 11, program address width; matches the CPU PC/MAR width.
- DATA_W, 14, instruction word width.
- DEPTH, 2048, number of RAM words; must equal 2**ADDR_W.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse that begins a load session
- abort  in  1  cancels an in-progress load
- word_count  in  ADDR_W+1  number of words to load; sampled on the start cycle
- in_data  in  DATA_W  instruction word
- in_valid  in  1  in_data is valid
- in_ready  out  1  loader accepts a word this cycle
- cpu_addr  in  ADDR_W  fetch address, driven by CPU MAR
- cpu_data  out  DATA_W  fetched instruction; 1-cycle registered latency
- cpu_hold  out  1  high keeps CPU in reset; system wiring ORs it with reset
- load_done  out  1  program loaded, CPU running
- checksum  out  16  running sum of accepted words
- wr_ptr  out  ADDR_W+1  number of words accepted in the current session

Behaviour:
- Clocking and reset: clock clk; reset is synchronous, active-high.
- Reset values:
  - state L_IDLE.
  - in_ready 0, cpu_hold 1, load_done 0.
  - checksum 0, wr_ptr 0, cpu_data 0.
  - RAM contents are not reset.
- State L_IDLE:
  - in_ready 0, cpu_hold 1, load_done 0.
  - start with word_count == 0: go to L_DONE, checksum 0.
  - start with word_count != 0: latch count = min(word_count, DEPTH); clear wr_ptr and checksum; go to L_LOAD.
- State L_LOAD:
  - in_ready is 1 (registered, asserted the cycle after entry).
  - A transfer occurs when in_valid && in_ready. On a transfer:
    - mem[wr_ptr] <= in_data
    - checksum <= checksum + zero-extended in_data, mod 2^16
    - wr_ptr++
  - If the transfer just taken is word count-1, go to L_DONE and drop in_ready the next cycle. No extra word is accepted.
  - in_valid may stall indefinitely; the state is held.
- State L_DONE:
  - cpu_hold 0, load_done 1, in_ready 0.
  - checksum and wr_ptr hold their values.
  - start re-enters the load path exactly as from L_IDLE, and cpu_hold returns to 1 on the next cycle.
- abort:
  - In L_LOAD: go to L_IDLE next cycle. A transfer in the abort cycle is still written. cpu_hold stays 1, load_done 0.
  - Ignored in other states.
- Simultaneous events:
  - start during L_LOAD is ignored.
  - start and abort in the same cycle: abort wins in L_LOAD; start wins otherwise.
- Read port:
  - cpu_data <= mem[cpu_addr] every cycle, in every state.
  - Same-address write and read in one cycle returns the old data (read-before-write).
  - 1-cycle latency fits the CPU flow: MAR loaded in T1, IR captured in T3.
- Reset mid-load: forces L_IDLE and cpu_hold 1. RAM keeps the partial contents.
- Timing: no combinational path from in_valid to in_ready.

Decomposition:
- Package prog_mem_pkg holds:
  - constants ADDR_W, DATA_W, DEPTH
  - typedef enum logic [1:0] loader_state_t {L_IDLE, L_LOAD, L_DONE}
- One sub-module, prog_ram: simple dual-port RAM with one write port and one registered read port (DATA_W x DEPTH).

Test Plan:
1. Reset, then start with word_count=3 and words 0x3005, 0x3E03, 0x3A0F sent back-to-back -> in_ready high for 3 transfers, then low. load_done=1 and cpu_hold=0 one cycle after the 3rd transfer. checksum=0xA817, wr_ptr=3.
2. After case 1, cpu_addr=0,1,2 on successive cycles -> cpu_data=0x3005, 0x3E03, 0x3A0F, each one cycle after its address.
3. word_count=4 with in_valid toggled 1,0,0,1,1,0,1 -> exactly 4 words written at addresses 0-3, and load_done rises only after the 4th transfer.
4. word_count=5, abort after 2 transfers -> state L_IDLE, load_done=0, cpu_hold=1, wr_ptr=2. A following start with word_count=1 completes normally.
5. start with word_count=0 -> L_DONE next cycle, checksum=0, no writes. start with word_count=0xFFF -> clamped; load_done after exactly 2048 transfers.
6. Reset asserted mid-load after 1 word -> all outputs at reset values next cycle. start during L_LOAD is ignored (wr_ptr unaffected). Read-during-write to address 0 returns the prior contents.
